// File: rtl/sata_transport_pkg.sv
// Shared SATA transport-layer definitions: FIS type codes, tuser bit positions
// and the depacketizer state encoding.
package sata_transport_pkg;

  localparam logic [7:0] FIS_DATA = 8'h46;

  // tuser layout, LSB first: eop, sop, keep[3:0], err, drop
  localparam int TU_EOP     = 0;
  localparam int TU_SOP     = 1;
  localparam int TU_KEEP_LO = 2;
  localparam int TU_KEEP_HI = 5;
  localparam int TU_ERR     = 6;
  localparam int TU_DROP    = 7;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_DROP = 2'd2,
    ST_TERM = 2'd3
  } depkt_state_e;

endpackage

// File: rtl/afx_skid_buffer.sv
// Small register FIFO used as an output skid stage; data is registered so a
// pushed word is visible on m_valid the cycle after the push.
module afx_skid_buffer #(
  parameter int DW = 32,
  parameter int DP = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] push_data,
  input  logic          push,
  output logic          full,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  localparam int AW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] mem_reg [DP];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_reg == CW'(DP));
  assign m_valid = (cnt_reg != '0);
  assign do_push = push & ~full;
  assign do_pop  = m_valid & m_ready;
  // Idle output is forced to zero so stale entries never leak onto the bus.
  assign m_data  = m_valid ? mem_reg[rd_ptr_reg] : '0;

  for (genvar gi = 0; gi < DP; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (do_push && (wr_ptr_reg == AW'(gi))) begin
        mem_reg[gi] <= push_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= (wr_ptr_reg == AW'(DP - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= (rd_ptr_reg == AW'(DP - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_reg <= cnt_reg + 1'b1;
        2'b01:   cnt_reg <= cnt_reg - 1'b1;
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

endmodule

// File: rtl/sata_transport_depacket.sv
// Strips Data FIS headers and forwards payload dwords to the DMA stream.
// Optional SATA_DEPKT_LEN_CHECK_EN enforces a MAX_DW payload length limit.
module sata_transport_depacket
  import sata_transport_pkg::*;
#(
  parameter int USER_W = 8,
  parameter int MAX_DW = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       s_aixs_link_tdata,
  input  logic [USER_W-1:0] s_aixs_link_tuser,
  input  logic              s_aixs_link_tvalid,
  output logic              s_aixs_link_tready,
  output logic [31:0]       m_aixs_trans_tdata,
  output logic [USER_W-1:0] m_aixs_trans_tuser,
  output logic              m_aixs_trans_tvalid,
  input  logic              m_aixs_trans_tready,
  output logic              err_fis_type,
  output logic              err_empty,
  output logic              err_orphan,
  output logic              err_trunc,
  output logic              err_len
);

  localparam int DW = 32 + USER_W;

`ifdef SATA_DEPKT_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  depkt_state_e      state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              first_reg, first_next;

  logic              skid_full;
  logic              push;
  logic [31:0]       push_tdata;
  logic [USER_W-1:0] push_tuser;
  logic [DW-1:0]     skid_dout;

  logic              in_sop, in_eop, is_data_fis, accept, len_hit;

  assign in_sop      = s_aixs_link_tuser[TU_SOP];
  assign in_eop      = s_aixs_link_tuser[TU_EOP];
  assign is_data_fis = (s_aixs_link_tdata[7:0] == FIS_DATA);
  assign len_hit     = LEN_EN & (cnt_reg == CNT_W'(MAX_DW - 1)) & ~in_eop;

  // A new sop seen in DATA is refused so it stays on the bus until TERM is done.
  assign s_aixs_link_tready = rst_n & ~skid_full & (state_reg != ST_TERM) &
                              ~((state_reg == ST_DATA) & s_aixs_link_tvalid & in_sop);
  assign accept = s_aixs_link_tvalid & s_aixs_link_tready;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    first_next   = first_reg;
    push         = 1'b0;
    push_tdata   = s_aixs_link_tdata;
    push_tuser   = s_aixs_link_tuser;
    err_fis_type = 1'b0;
    err_empty    = 1'b0;
    err_orphan   = 1'b0;
    err_trunc    = 1'b0;
    err_len      = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DROP: begin
        if (accept) begin
          if (in_sop) begin
            if (is_data_fis) begin
              if (in_eop) begin
                err_empty  = 1'b1;
                state_next = ST_IDLE;
              end else begin
                state_next = ST_DATA;
                cnt_next   = '0;
                first_next = 1'b1;
              end
            end else begin
              err_fis_type = 1'b1;
              state_next   = in_eop ? ST_IDLE : ST_DROP;
            end
          end else if (state_reg == ST_IDLE) begin
            err_orphan = 1'b1;
          end else if (in_eop) begin
            state_next = ST_IDLE;
          end
        end
      end

      ST_DATA: begin
        if (accept) begin
          push               = 1'b1;
          push_tuser[TU_SOP] = first_reg;
          first_next         = 1'b0;
          if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
          end
          if (in_eop) begin
            state_next = ST_IDLE;
          end else if (len_hit) begin
            push_tuser[TU_EOP] = 1'b1;
            push_tuser[TU_ERR] = 1'b1;
            err_len            = 1'b1;
            state_next         = ST_DROP;
          end
        end else if (s_aixs_link_tvalid && in_sop) begin
          state_next = ST_TERM;
        end
      end

      ST_TERM: begin
        if (!skid_full) begin
          push               = 1'b1;
          push_tdata         = '0;
          push_tuser         = '0;
          push_tuser[TU_ERR] = 1'b1;
          push_tuser[TU_EOP] = 1'b1;
          err_trunc          = 1'b1;
          state_next         = ST_IDLE;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      first_reg <= first_next;
    end
  end

  afx_skid_buffer #(
    .DW (DW),
    .DP (2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_data ({push_tuser, push_tdata}),
    .push      (push),
    .full      (skid_full),
    .m_data    (skid_dout),
    .m_valid   (m_aixs_trans_tvalid),
    .m_ready   (m_aixs_trans_tready)
  );

  assign m_aixs_trans_tdata = skid_dout[31:0];
  assign m_aixs_trans_tuser = skid_dout[DW-1:32];

endmodule

// File: tb/tb_sata_transport_depacket.sv
// Directed self-checking bench for sata_transport_depacket; honours
// SATA_DEPKT_LEN_CHECK_EN for the long-payload case.
module tb_sata_transport_depacket;

  localparam int USER_W = 8;
  localparam logic [7:0] U_SOP = 8'h02;
  localparam logic [7:0] U_EOP = 8'h01;
  localparam logic [7:0] U_K   = 8'h3C;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       s_tdata = '0;
  logic [USER_W-1:0] s_tuser = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic [31:0]       m_tdata;
  logic [USER_W-1:0] m_tuser;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic              err_fis_type, err_empty, err_orphan, err_trunc, err_len;

  always #5 clk = ~clk;

  sata_transport_depacket #(
    .USER_W (USER_W),
    .MAX_DW (2048)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .s_aixs_link_tdata   (s_tdata),
    .s_aixs_link_tuser   (s_tuser),
    .s_aixs_link_tvalid  (s_tvalid),
    .s_aixs_link_tready  (s_tready),
    .m_aixs_trans_tdata  (m_tdata),
    .m_aixs_trans_tuser  (m_tuser),
    .m_aixs_trans_tvalid (m_tvalid),
    .m_aixs_trans_tready (m_tready),
    .err_fis_type        (err_fis_type),
    .err_empty           (err_empty),
    .err_orphan          (err_orphan),
    .err_trunc           (err_trunc),
    .err_len             (err_len)
  );

  int checks = 0;
  int errors = 0;
  bit quiet = 1'b0;

  logic [39:0] out_q[$];
  logic [39:0] exp_q[$];
  int base;
  int n_fis_type = 0, n_empty = 0, n_orphan = 0, n_trunc = 0, n_len = 0, n_stall = 0;
  int s_fis_type, s_empty, s_orphan, s_trunc, s_len, s_stall;

  // Output handshake completes at the next rising edge; inputs only move just after rising edges.
  always @(negedge clk) begin
    if (m_tvalid && m_tready) begin
      out_q.push_back({m_tuser, m_tdata});
      if (!quiet) $display("OUT beat %0d data=%h user=%h", out_q.size() - 1, m_tdata, m_tuser);
    end
    if (err_fis_type) n_fis_type++;
    if (err_empty)    n_empty++;
    if (err_orphan)   n_orphan++;
    if (err_trunc)    n_trunc++;
    if (err_len)      n_len++;
    if (!m_tready && !s_tready) n_stall++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int err_total();
    return n_fis_type + n_empty + n_orphan + n_trunc + n_len;
  endfunction

  task automatic start_test();
    base = out_q.size();
    exp_q.delete();
    s_fis_type = n_fis_type; s_empty = n_empty; s_orphan = n_orphan;
    s_trunc = n_trunc; s_len = n_len; s_stall = n_stall;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [7:0] u);
    exp_q.push_back({u, d});
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [31:0] d, input logic [7:0] u);
    int n;
    n = 0;
    s_tdata = d; s_tuser = u; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) check_eq("tready_wait", {63'd0, s_tready}, 64'd1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    repeat (20) @(posedge clk);
    #1;
    check_eq({tag, "_count"}, out_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < out_q.size(); i++)
      check_eq($sformatf("%s_beat%0d", tag, i), out_q[base + i], exp_q[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    check_eq("rst_s_tready", {63'd0, s_tready}, 64'd0);
    check_eq("rst_m_data",   {24'd0, m_tuser, m_tdata}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
    @(posedge clk); #1;

    // Basic Data FIS, latency of first payload beat, drop bit passthrough
    start_test();
    send_beat(32'h0000_0046, U_SOP);
    send_beat(32'hAAAA_0001, U_K);
    @(negedge clk);
    check_eq("t1_latency_valid", {63'd0, m_tvalid}, 64'd1);
    check_eq("t1_latency_data",  {24'd0, m_tuser, m_tdata}, {24'd0, 8'h3E, 32'hAAAA_0001});
    @(posedge clk); #1;
    send_beat(32'hBBBB_0002, 8'hBC);
    send_beat(32'hCCCC_0003, U_K | U_EOP);
    expect_beat(32'hAAAA_0001, 8'h3E);
    expect_beat(32'hBBBB_0002, 8'hBC);
    expect_beat(32'hCCCC_0003, 8'h3D);
    compare_out("t1");
    check_eq("t1_errs", err_total() - (s_fis_type + s_empty + s_orphan + s_trunc + s_len), 0);

    // Non-data FIS dropped, following Data FIS forwarded
    start_test();
    send_beat(32'h0000_0034, U_SOP);
    for (int i = 0; i < 4; i++) send_beat(32'h3400_0000 + i, (i == 3) ? (U_K | U_EOP) : U_K);
    send_beat(32'h0000_0046, U_SOP);
    send_beat(32'h1111_2222, U_K | U_EOP);
    expect_beat(32'h1111_2222, 8'h3F);
    compare_out("t2");
    check_eq("t2_fis_type", n_fis_type - s_fis_type, 1);
    check_eq("t2_errs", err_total() - (s_fis_type + s_empty + s_orphan + s_trunc + s_len), 1);

    // Truncated FIS: terminator inserted, next FIS intact
    start_test();
    send_beat(32'h0000_0046, U_SOP);
    send_beat(32'h5000_0000, U_K);
    send_beat(32'h5000_0001, U_K);
    send_beat(32'h0000_0046, U_SOP);
    send_beat(32'h6000_0000, U_K);
    send_beat(32'h6000_0001, U_K | U_EOP);
    expect_beat(32'h5000_0000, 8'h3E);
    expect_beat(32'h5000_0001, 8'h3C);
    expect_beat(32'h0000_0000, 8'h41);
    expect_beat(32'h6000_0000, 8'h3E);
    expect_beat(32'h6000_0001, 8'h3D);
    compare_out("t3");
    check_eq("t3_trunc", n_trunc - s_trunc, 1);
    check_eq("t3_errs", err_total() - (s_fis_type + s_empty + s_orphan + s_trunc + s_len), 1);

    // Downstream stall during an 8-dword payload
    start_test();
    fork
      begin
        send_beat(32'h0000_0046, U_SOP);
        for (int i = 0; i < 8; i++) send_beat(32'h7000_0000 + i, (i == 7) ? (U_K | U_EOP) : U_K);
      end
      begin
        repeat (3) @(posedge clk);
        #1 m_tready = 1'b0;
        repeat (10) @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    for (int i = 0; i < 8; i++)
      expect_beat(32'h7000_0000 + i, (i == 0) ? 8'h3E : ((i == 7) ? 8'h3D : 8'h3C));
    compare_out("t4");
    check_eq("t4_stall_seen", {63'd0, (n_stall > s_stall)}, 64'd1);

    // Empty Data FIS and orphan beat
    start_test();
    send_beat(32'h0000_0046, U_SOP | U_EOP);
    send_beat(32'h0000_1234, U_K | U_EOP);
    compare_out("t5");
    check_eq("t5_empty",  n_empty - s_empty, 1);
    check_eq("t5_orphan", n_orphan - s_orphan, 1);

    // Reset mid-packet with data parked in the skid buffer
    start_test();
    m_tready = 1'b0;
    send_beat(32'h0000_0046, U_SOP);
    send_beat(32'h8000_0000, U_K);
    send_beat(32'h8000_0001, U_K);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_tready = 1'b1;
    @(negedge clk);
    check_eq("t6_m_tvalid_after_rst", {63'd0, m_tvalid}, 64'd0);
    @(posedge clk); #1;
    send_beat(32'h8000_0002, U_K | U_EOP);
    send_beat(32'h0000_0046, U_SOP);
    send_beat(32'h9000_0000, U_K);
    send_beat(32'h9000_0001, U_K | U_EOP);
    expect_beat(32'h9000_0000, 8'h3E);
    expect_beat(32'h9000_0001, 8'h3D);
    compare_out("t6");
    check_eq("t6_orphan", n_orphan - s_orphan, 1);
    check_eq("t6_trunc",  n_trunc - s_trunc, 0);

    // 2050-dword payload against the length limit
    start_test();
    quiet = 1'b1;
    send_beat(32'h0000_0046, U_SOP);
    for (int i = 0; i < 2050; i++) send_beat(32'h5A00_0000 + i, (i == 2049) ? (U_K | U_EOP) : U_K);
    repeat (20) @(posedge clk);
    #1;
    quiet = 1'b0;
    check_eq("t7_first", out_q[base], {8'h3E, 32'h5A00_0000});
`ifdef SATA_DEPKT_LEN_CHECK_EN
    check_eq("t7_count", out_q.size() - base, 2048);
    check_eq("t7_last",  out_q[out_q.size() - 1], {8'h7D, 32'h5A00_07FF});
    check_eq("t7_len",   n_len - s_len, 1);
`else
    check_eq("t7_count", out_q.size() - base, 2050);
    check_eq("t7_b2047", out_q[base + 2047], {8'h3C, 32'h5A00_07FF});
    check_eq("t7_last",  out_q[out_q.size() - 1], {8'h3D, 32'h5A00_0801});
    check_eq("t7_len",   n_len - s_len, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sata_transport_depacket.md
SATA_TRANSPORT_DEPACKET -- requirements
Module: sata_transport_depacket

Interface
REQ-001 SHALL have parameter USER_W, default 8, tuser width {drop,err,keep[3:0],sop,eop}.
REQ-002 SHALL have parameter MAX_DW, default 2048, max Data FIS payload dwords.
REQ-003 clk  input  1  clock; reset rst_n, asynchronous, active-low.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 s_aixs_link_tdata/tuser/tvalid  input  32/USER_W/1  FIS stream from link layer; tready output 1.
REQ-006 m_aixs_trans_tdata/tuser/tvalid  output  32/USER_W/1  payload stream to DMA; tready input 1.
REQ-007 err_fis_type, err_empty, err_orphan, err_trunc, err_len  output  1 each  single-cycle status pulses.

Function
REQ-008 SHALL strip the header dword (sop beat) of each Data FIS (tdata[7:0]==8'h46) and forward only payload dwords.
REQ-009 SHALL register output through a 2-entry skid buffer; accepted payload beat appears on m_aixs_trans_tvalid exactly 1 cycle later when output empty.
REQ-010 s_aixs_link_tready SHALL equal ~skid_full except in state TERM, where it is 0.
REQ-011 FSM states: IDLE, DATA, DROP, TERM; reset state IDLE.
REQ-012 IDLE, sop beat, type 8'h46, no eop -> DATA, count cleared, first-payload flag set; nothing pushed.
REQ-013 IDLE, sop beat, type 8'h46 with eop -> stay IDLE, err_empty pulse, nothing pushed.
REQ-014 IDLE, sop beat, type != 8'h46 -> DROP (IDLE if eop on same beat), err_fis_type pulse.
REQ-015 IDLE, non-sop beat -> discarded, err_orphan pulse, stay IDLE.
REQ-016 DATA, non-sop beat -> pushed; out sop = first-payload flag (then cleared); out eop = in eop; keep/drop/err copied; count += 1; eop -> IDLE.
REQ-017 DATA, sop beat -> TERM without accepting it; TERM pushes one terminator (tdata 0, keep 4'b0000, err 1, eop 1, sop 0), err_trunc pulse, then IDLE, where the held sop beat is evaluated per REQ-012..014.
REQ-018 TERM SHALL wait while skid full; terminator pushed on first non-full cycle.
REQ-019 DROP: beats accepted and discarded; eop -> IDLE; sop in DROP re-evaluated as in IDLE.
REQ-020 Payload counter 12 bits, saturating, never wraps.
REQ-021 Payload drop bit (tuser[7]) SHALL be forwarded unchanged; module SHALL not discard on it.
REQ-022 Status pulses SHALL be high for exactly the cycle the causing beat is accepted (TERM: push cycle).

Reset
REQ-023 On rst_n low: FSM IDLE, counter 0, first flag 0, skid emptied, m_aixs_trans_tvalid 0, tdata/tuser 0, all err pulses 0, s_aixs_link_tready 0 during reset.
REQ-024 Reset mid-packet SHALL discard partial packet; no terminator emitted after reset release.

Configuration
REQ-025 Macro SATA_DEPKT_LEN_CHECK_EN: defined -> payload beat number MAX_DW without eop is pushed with eop=1, err=1, err_len pulse, FSM -> DROP.
REQ-026 Undefined -> no length limit, err_len tied 0, counter still maintained.

Structure
REQ-027 Shared package sata_transport_pkg SHALL hold FIS type constant FIS_DATA=8'h46, tuser bit-index localparams, FSM state enum.
REQ-028 Output buffering SHALL use existing sub-module afx_skid_buffer (DW=32+USER_W, DP=2); FSM/counter in this module.

Verification
REQ-029 Header 0x00000046 sop + 3 payload dwords A,B,C (eop on C) -> out A(sop),B,C(eop), 3 beats, no errors.
REQ-030 Header 0x00000034 + 4 beats -> no output, err_fis_type one pulse, then next Data FIS forwarded normally.
REQ-031 Data FIS header + 2 payload, then new sop 0x46 before eop -> out P0(sop),P1,terminator(keep 0,err 1,eop 1), err_trunc; next FIS forwarded intact.
REQ-032 m_aixs_trans_tready low 10 cycles during 8-dword payload -> s_aixs_link_tready low once skid full, no loss/duplication, order preserved.
REQ-033 With SATA_DEPKT_LEN_CHECK_EN, 2050-dword payload -> beat 2048 has eop=1, err=1, err_len pulse, remaining 2 dropped; without macro all 2050 forwarded.
REQ-034 rst_n asserted mid-payload, then clean FIS -> only clean FIS output, sop on first beat, no terminator.
